fp_int_wb_arbiter: RTL

- Shares one integer writeback port among NUM_UNITS FP units that produce integer-register results (e.g. the compare/classify/convert/move unit and FDIV/FSQRT flag-only paths).
- Round-robin arbitration over the units' done/ack handshakes.
- One registered output stage carries result, instruction id and fflags toward the integer writeback/commit logic.
- Sits between the FP unit writeback interfaces and the core's writeback port.

---
 rtl/fp_int_wb_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/fp_int_wb_arbiter.sv
// fp_int_wb_arbiter: round-robin arbiter that shares one integer writeback
// port among NUM_UNITS FP units. A single registered output stage carries
// result, id and fflags to the core. Throughput is one result per cycle, and
// the grant-to-wb_done latency is one cycle.
module fp_int_wb_arbiter #(
  parameter  int NUM_UNITS = 2,
  parameter  int ID_W      = 3,
  parameter  int DATA_W    = 32,
  localparam int GW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_UNITS-1:0]              unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]    unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]  unit_rd,
  input  logic [NUM_UNITS-1:0][4:0]         unit_fflags,
  output logic [NUM_UNITS-1:0]              unit_ack,
  output logic                              wb_done,
  output logic [ID_W-1:0]                   wb_id,
  output logic [DATA_W-1:0]                 wb_rd,
  output logic [4:0]                        wb_fflags,
  input  logic                              wb_ack,
  output logic [GW-1:0]                     wb_grant_unit
);

  logic              wb_done_q, wb_done_d;
  logic [ID_W-1:0]   wb_id_q, wb_id_d;
  logic [DATA_W-1:0] wb_rd_q, wb_rd_d;
  logic [4:0]        wb_fflags_q, wb_fflags_d;
  logic [GW-1:0]     grant_unit_q, grant_unit_d;
  logic [GW-1:0]     ptr_q, ptr_d;

  logic              advance;
  logic              grant_valid;
  logic [GW-1:0]     grant_idx;
  logic              ack_en;

  // The output stage can accept a new result when empty or retiring this cycle.
  assign advance = ~wb_done_q | wb_ack;

  // Rotating priority scan: the first pending unit at or after ptr wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_UNITS;
      if (!grant_valid && unit_done[GW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

  // Acks are suppressed during reset so units do not lose results that are dropped.
  assign ack_en = advance & grant_valid & ~rst;

  // One-hot ack to the granted unit.
  always_comb begin
    unit_ack = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_ack[i] = ack_en && (grant_idx == GW'(i));
    end
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    wb_done_d    = wb_done_q & ~wb_ack;
    wb_id_d      = wb_id_q;
    wb_rd_d      = wb_rd_q;
    wb_fflags_d  = wb_fflags_q;
    grant_unit_d = grant_unit_q;
    ptr_d        = ptr_q;
    if (ack_en) begin
      wb_done_d    = 1'b1;
      wb_id_d      = unit_id[grant_idx];
      wb_rd_d      = unit_rd[grant_idx];
      wb_fflags_d  = unit_fflags[grant_idx];
      grant_unit_d = grant_idx;
      ptr_d        = GW'((int'(grant_idx) + 1) % NUM_UNITS);
    end
  end

  // Output stage and pointer registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_done_q    <= 1'b0;
      wb_id_q      <= '0;
      wb_rd_q      <= '0;
      wb_fflags_q  <= '0;
      grant_unit_q <= '0;
      ptr_q        <= '0;
    end else begin
      wb_done_q    <= wb_done_d;
      wb_id_q      <= wb_id_d;
      wb_rd_q      <= wb_rd_d;
      wb_fflags_q  <= wb_fflags_d;
      grant_unit_q <= grant_unit_d;
      ptr_q        <= ptr_d;
    end
  end

  assign wb_done       = wb_done_q;
  assign wb_id         = wb_id_q;
  assign wb_rd         = wb_rd_q;
  assign wb_fflags     = wb_fflags_q;
  assign wb_grant_unit = grant_unit_q;

endmodule
